// File: rtl/uart_timing_gen.sv
// UART timing front end: baud clocks (1x/8x), slow clock with tick, and a synchronized rising-edge
// pulse. Define LEVEL_DET_SLOW_EN to gate the edge detector to slow_tick cycles.
module uart_timing_gen #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned BAUD_SEL    = 0,
  parameter int unsigned SLOW_CYCLES = 100_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in,
  output logic o_bclk,
  output logic o_bclk_x8,
  output logic o_baud_tick,
  output logic o_slow_clk,
  output logic o_slow_tick,
  output logic o_pulse
);

  localparam int unsigned BAUD = (BAUD_SEL == 1) ? 19200  :
                                 (BAUD_SEL == 2) ? 57600  :
                                 (BAUD_SEL == 3) ? 115200 : 9600;
  localparam int unsigned HALF_X8   = CLK_FREQ / (16 * BAUD);
  localparam int unsigned HALF_SLOW = SLOW_CYCLES / 2;
  localparam int unsigned X8W = (HALF_X8 > 1) ? $clog2(HALF_X8) : 1;
  localparam int unsigned SW  = (HALF_SLOW > 1) ? $clog2(HALF_SLOW) : 1;
  localparam logic [X8W-1:0] X8_LAST   = X8W'(HALF_X8 - 1);
  localparam logic [SW-1:0]  SLOW_LAST = SW'(HALF_SLOW - 1);

  logic [X8W-1:0] r_x8_cnt, w_x8_cnt_d;
  logic [SW-1:0]  r_slow_cnt, w_slow_cnt_d;
  logic [2:0]     r_bit_cnt, w_bit_cnt_d;
  logic r_bclk_x8, w_bclk_x8_d, r_bclk, w_bclk_d, r_baud_tick, w_baud_tick_d;
  logic r_slow_clk, w_slow_clk_d, r_slow_tick, w_slow_tick_d;
  logic r_s1, r_s2, r_prev, w_prev_d, r_pulse, w_pulse_d;
  logic w_x8_wrap, w_slow_wrap;

  always_comb begin
    w_x8_wrap     = (r_x8_cnt == X8_LAST);
    w_x8_cnt_d    = w_x8_wrap ? '0 : r_x8_cnt + X8W'(1);
    w_bclk_x8_d   = r_bclk_x8 ^ w_x8_wrap;
    w_bit_cnt_d   = r_bit_cnt + {2'b00, w_x8_wrap};
    // bclk flips when the 3-bit toggle counter wraps 7 -> 0
    w_bclk_d      = r_bclk ^ (w_x8_wrap && (r_bit_cnt == 3'd7));
    w_baud_tick_d = w_bclk_d & ~r_bclk;

    w_slow_wrap   = (r_slow_cnt == SLOW_LAST);
    w_slow_cnt_d  = w_slow_wrap ? '0 : r_slow_cnt + SW'(1);
    w_slow_clk_d  = r_slow_clk ^ w_slow_wrap;
    w_slow_tick_d = w_slow_clk_d & ~r_slow_clk;

`ifdef LEVEL_DET_SLOW_EN
    // Evaluate on the edge that raises slow_tick so pulse lines up with it
    w_prev_d  = r_prev;
    w_pulse_d = 1'b0;
    if (w_slow_tick_d) begin
      w_prev_d  = r_s2;
      w_pulse_d = r_s2 & ~r_prev;
    end
`else
    w_prev_d  = r_s2;
    w_pulse_d = r_s2 & ~r_prev;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x8_cnt    <= '0;
      r_bclk_x8   <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_bclk      <= 1'b0;
      r_baud_tick <= 1'b0;
      r_slow_cnt  <= '0;
      r_slow_clk  <= 1'b0;
      r_slow_tick <= 1'b0;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_prev      <= 1'b0;
      r_pulse     <= 1'b0;
    end else begin
      r_x8_cnt    <= w_x8_cnt_d;
      r_bclk_x8   <= w_bclk_x8_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_bclk      <= w_bclk_d;
      r_baud_tick <= w_baud_tick_d;
      r_slow_cnt  <= w_slow_cnt_d;
      r_slow_clk  <= w_slow_clk_d;
      r_slow_tick <= w_slow_tick_d;
      r_s1        <= i_in;
      r_s2        <= r_s1;
      r_prev      <= w_prev_d;
      r_pulse     <= w_pulse_d;
    end
  end

  assign o_bclk      = r_bclk;
  assign o_bclk_x8   = r_bclk_x8;
  assign o_baud_tick = r_baud_tick;
  assign o_slow_clk  = r_slow_clk;
  assign o_slow_tick = r_slow_tick;
  assign o_pulse     = r_pulse;

endmodule

// File: tb/tb_uart_timing_gen.sv
// Randomized bench for uart_timing_gen: three baud selects side by side, checked every cycle
// against closed-form timing expressions and an input-history edge model.
module tb_uart_timing_gen;

  localparam int unsigned ClkFreq    = 100_000_000;
  localparam int unsigned SlowCycles = 10;
  localparam int unsigned NumDut     = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_lvl = 1'b0;
  logic [NumDut-1:0] bclk, bclk_x8, btick, sclk, stick, pulse;

  int unsigned sel_tab [NumDut] = '{0, 3, 7};
  int unsigned t;
  logic        hist [0:65535];
  logic        m_prev, m_pulse;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  uart_timing_gen #(.CLK_FREQ(ClkFreq), .BAUD_SEL(0), .SLOW_CYCLES(SlowCycles)) u_dut_s0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(in_lvl), .o_bclk(bclk[0]), .o_bclk_x8(bclk_x8[0]),
    .o_baud_tick(btick[0]), .o_slow_clk(sclk[0]), .o_slow_tick(stick[0]), .o_pulse(pulse[0]));
  uart_timing_gen #(.CLK_FREQ(ClkFreq), .BAUD_SEL(3), .SLOW_CYCLES(SlowCycles)) u_dut_s3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(in_lvl), .o_bclk(bclk[1]), .o_bclk_x8(bclk_x8[1]),
    .o_baud_tick(btick[1]), .o_slow_clk(sclk[1]), .o_slow_tick(stick[1]), .o_pulse(pulse[1]));
  uart_timing_gen #(.CLK_FREQ(ClkFreq), .BAUD_SEL(7), .SLOW_CYCLES(SlowCycles)) u_dut_s7 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(in_lvl), .o_bclk(bclk[2]), .o_bclk_x8(bclk_x8[2]),
    .o_baud_tick(btick[2]), .o_slow_clk(sclk[2]), .o_slow_tick(stick[2]), .o_pulse(pulse[2]));

  function automatic int unsigned half_x8(input int unsigned sel);
    int unsigned baud;
    case (sel)
      1:       baud = 19200;
      2:       baud = 57600;
      3:       baud = 115200;
      default: baud = 9600;
    endcase
    return ClkFreq / (16 * baud);
  endfunction

  // Order: {bclk_x8, bclk, baud_tick, slow_clk, slow_tick, pulse}; t = edges since release
  function automatic logic [5:0] expect_vec(input int unsigned h);
    logic [5:0] v;
    if (!rst_n) return 6'b0;
    v[5] = ((t / h) % 2) == 1;
    v[4] = ((t / (8 * h)) % 2) == 1;
    v[3] = (t % (16 * h)) == 8 * h;
    v[2] = ((t / (SlowCycles / 2)) % 2) == 1;
    v[1] = (t % SlowCycles) == SlowCycles / 2;
    v[0] = m_pulse;
    return v;
  endfunction

  task automatic check_eq(input string tag, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%b want=%b", tag, t, act, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NumDut; i++) begin
      check_eq($sformatf("sel%0d", sel_tab[i]),
               {bclk_x8[i], bclk[i], btick[i], sclk[i], stick[i], pulse[i]},
               expect_vec(half_x8(sel_tab[i])));
    end
  endtask

  task automatic step();
    logic s2;
    @(posedge clk);
    if (rst_n) begin
      t++;
      hist[t] = in_lvl;
      s2 = (t >= 2) ? hist[t-2] : 1'b0;
`ifdef LEVEL_DET_SLOW_EN
      if ((t % SlowCycles) == SlowCycles / 2) begin
        m_pulse = s2 & ~m_prev;
        m_prev  = s2;
      end else begin
        m_pulse = 1'b0;
      end
`else
      m_pulse = (t >= 3) ? (s2 & ~hist[t-3]) : 1'b0;
`endif
    end else begin
      t       = 0;
      m_pulse = 1'b0;
      m_prev  = 1'b0;
    end
    #1;
    check_all();
  endtask

  task automatic random_run(input int unsigned until_t);
    while (t < until_t) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) in_lvl = ~in_lvl;
      step();
    end
  endtask

  initial begin
    hist[0] = 1'b0;
    t       = 0;
    m_prev  = 1'b0;
    m_pulse = 1'b0;
    repeat (5) step();
    @(negedge clk) rst_n = 1'b1;
    repeat (2000) step();
    // Single long rise, fall, then two rises 10 clks apart
    @(negedge clk) in_lvl = 1'b1;
    repeat (50) step();
    @(negedge clk) in_lvl = 1'b0;
    repeat (20) step();
    @(negedge clk) in_lvl = 1'b1;
    repeat (5) step();
    @(negedge clk) in_lvl = 1'b0;
    repeat (5) step();
    @(negedge clk) in_lvl = 1'b1;
    repeat (5) step();
    @(negedge clk) in_lvl = 1'b0;
    repeat (20) step();
    random_run(22000);
    // Asynchronous reset mid-cycle at slow count 3; outputs must clear without a clock edge
    while ((t % (SlowCycles / 2)) != 3) step();
    #2 rst_n = 1'b0;
    #1 check_all();
    in_lvl = 1'b1;
    repeat (5) step();
    @(negedge clk) rst_n = 1'b1;
    repeat (100) step();
    random_run(12000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_timing_gen.md
Name: uart_timing_gen

Overview:
Timing and input-conditioning front end for the UART matrix-transfer path. It produces three things:
- Baud-rate clocks: bclk at 1x and bclk_x8 at 8x, for the transmitter and receiver.
- A slow clock, slow_clk, plus a one-cycle slow_tick strobe, for the user-paced control FSM.
- A single-cycle rising-edge pulse derived from a level input, such as the read_R_mat switch.

All logic runs in the single clk domain.

Parameters:
- CLK_FREQ, 100_000_000: input clock frequency in Hz.
- BAUD_SEL, 0: baud select. 0=9600, 1=19200, 2=57600, 3=115200; any other value behaves as 0.
- SLOW_CYCLES, 100_000_000: slow_clk period in clk cycles. Must be even and >=2.

Ports:
- clk, input, 1: system clock, rising-edge active.
- rst, input, 1: asynchronous, active-low reset (0 = reset).
- in, input, 1: asynchronous level input to edge-detect.
- bclk, output, 1: 1x baud square wave.
- bclk_x8, output, 1: 8x baud square wave.
- baud_tick, output, 1: one-clk strobe on each bclk 0->1 transition.
- slow_clk, output, 1: slow square wave.
- slow_tick, output, 1: one-clk strobe on each slow_clk 0->1 transition.
- pulse, output, 1: one-clk strobe on each rising edge of in.

Behaviour:
- Reset (rst=0, asynchronous): all counters, synchronizer flops and outputs go to 0 immediately. Asserting reset mid-count abandons the count. After release, every count restarts from 0 on the first clk edge.
- Divisor: HALF_X8 = CLK_FREQ / (16 * baud), integer floor, constant. At 100 MHz: 651, 325, 108, 54 for BAUD_SEL 0..3.
- bclk_x8: registered. A half-counter counts 0..HALF_X8-1; on the cycle it holds HALF_X8-1 it wraps to 0 and bclk_x8 toggles. Period = 2*HALF_X8 clks, 50% duty.
- bclk: a 3-bit counter increments on every bclk_x8 toggle. When it wraps from 7 to 0, bclk toggles. Result: bclk period = 8 bclk_x8 periods, edge-aligned with bclk_x8 edges, first rise after 8*HALF_X8 clks.
- baud_tick: high for exactly the one clk cycle in which the registered bclk has just become 1.
- slow_clk: a counter counts 0..SLOW_CYCLES/2-1; on wrap, slow_clk toggles. Period = SLOW_CYCLES clks, 50% duty.
- slow_tick: high for the one cycle in which the registered slow_clk has just become 1.
- Edge detector:
  - in passes through a 2-flop synchronizer (s1, s2), then a history flop prev.
  - pulse is registered: pulse <= s2 & ~prev, with prev <= s2.
  - Latency: in rising before clk edge 1 gives pulse high after edge 3, low after edge 4.
  - Exactly one pulse per 0->1 level change, regardless of how long in stays high. No pulse on 1->0.
  - in already high when reset is released: prev resets to 0, so one pulse fires after synchronization. This is required.
  - A glitch shorter than one clk period may be missed. This is allowed.
- Simultaneous events: the baud, slow and edge paths are independent and may strobe in the same cycle.

Optional Feature:
- Macro LEVEL_DET_SLOW_EN.
- When defined: the synchronizer still samples every clk, but prev and pulse update only in cycles where slow_tick=1; in all other cycles pulse is 0. Effect: in is debounced at the slow rate, pulse stays one clk wide and is coincident with slow_tick.
- When undefined: prev and pulse update every clk, as described in Behaviour.

Test Plan:
- Reset/idle: hold rst=0 for 5 clks, then release -> all outputs 0 during reset; with in=0, pulse stays 0 for 2000 clks.
- Baud at BAUD_SEL=0, CLK_FREQ=100e6: bclk_x8 toggles every 651 clks (period 1302); bclk first rises 5208 clks after reset release, period 10416; baud_tick is 1 clk wide at each bclk rise.
- Baud at BAUD_SEL=3 and BAUD_SEL=7: bclk_x8 period is 108 clks for sel 3; sel 7 gives 1302 (falls back to 9600).
- Slow clock at SLOW_CYCLES=10: slow_clk toggles every 5 clks; slow_tick fires every 10 clks, 1 clk wide. Assert rst=0 at count 3 -> slow_clk=0 at once, and the count restarts from 0 after release.
- Edge detect: in 0->1 held 50 clks -> exactly one pulse, 1 clk wide, 3 edges after the change. in 1->0 -> no pulse. Two rises 10 clks apart -> two pulses.
- With LEVEL_DET_SLOW_EN and SLOW_CYCLES=10: in rises and stays high -> single pulse coincident with the next slow_tick after synchronization. in high for 3 clks, not spanning a slow_tick -> no pulse.
